ac_store_writer: RTL and testbench

Write-back path for the 10-bit accumulator. The control unit hands the block a store request (address plus the current AC value). The block buffers up to DEPTH requests and drives the data-memory write port with a we/ack handshake, so the CPU stalls only when the buffer is full. It sits between the AC output and data memory, the opposite direction to the AC load path.

---
 rtl/ac_store_writer_pkg.sv | 21 ++
 rtl/ac_store_writer_if.sv | 31 +++
 rtl/ac_store_writer_fifo.sv | 54 +++++
 rtl/ac_store_writer.sv | 107 ++++++++++
 tb/tb_ac_store_writer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ac_store_writer_pkg.sv
// ac_pkg: shared constants, FSM state encoding and store-entry layout for the
// accumulator write-back path (ac_store_writer and its store FIFO).
package ac_pkg;

    localparam int AC_DATA_W = 10;  // accumulator / stored word width
    localparam int AC_ADDR_W = 8;   // data-memory address width

    // Write-port sequencer states; the encoding is visible on dbg_state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Store-buffer entry layout: address in the upper bits, data in the lower.
    typedef struct packed {
        logic [AC_ADDR_W-1:0] addr;
        logic [AC_DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/ac_store_writer_if.sv
// ac_store_if: store-request handshake from the control unit plus the
// data-memory write port. The writer uses the slave modport; the control
// unit / memory side uses the master modport.
interface ac_store_if #(
    parameter int ADDR_W = ac_pkg::AC_ADDR_W,
    parameter int DATA_W = ac_pkg::AC_DATA_W
);
    // Handshakes:
    //  st_*  : a store transfers on a rising edge where st_valid && st_ready;
    //          st_ready depends only on the buffer fill level.
    //  mem_* : mem_we is held with stable mem_addr/mem_wdata until a rising
    //          edge where mem_ack=1; that edge completes the write.
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;

    modport master (
        output st_valid, st_addr, st_data, mem_ack,
        input  st_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  st_valid, st_addr, st_data, mem_ack,
        output st_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ac_store_writer_fifo.sv
// ac_store_fifo: DEPTH-entry synchronous FIFO for pending stores. With
// AC_STORE_FWD_EN defined, the entry array and read pointer are also exposed
// so the writer can search pending stores.
module ac_store_fifo #(
    parameter  int W     = 18,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
`ifdef AC_STORE_FWD_EN
    ,
    output logic [W-1:0]  entries_o [DEPTH],
    output logic [PW-1:0] rd_ptr_o
`endif
);

    logic [W-1:0]  entries [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Entry storage carries no reset; only the count says what is valid.
    always_ff @(posedge clk) begin
        if (push) entries[wr_ptr] <= wdata;
    end

    assign head = entries[rd_ptr];

`ifdef AC_STORE_FWD_EN
    assign entries_o = entries;
    assign rd_ptr_o  = rd_ptr;
`endif

endmodule

// File: rtl/ac_store_writer.sv
// ac_store_writer: buffers accumulator store requests and drains them in
// order to data memory through a we/ack write port, with one idle turnaround
// cycle after every acknowledged write.
// Optional feature macro AC_STORE_FWD_EN: adds a combinational lookup
// (fwd_addr -> fwd_hit/fwd_data) over all pending stores, youngest match wins.
module ac_store_writer
    import ac_pkg::*;
#(
    parameter int DATA_W = AC_DATA_W,
    parameter int ADDR_W = AC_ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    ac_store_if.slave   bus,
    output logic        idle,
    output state_e      dbg_state
`ifdef AC_STORE_FWD_EN
    ,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    localparam int W  = ADDR_W + DATA_W;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    state_e        state;
    state_e        state_next;
    logic          push;
    logic          pop;
    logic [W-1:0]  head;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

`ifdef AC_STORE_FWD_EN
    logic [W-1:0]  entries [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] idx;
`endif

    assign bus.st_ready = (count != CW'(DEPTH));
    assign push         = bus.st_valid && bus.st_ready;
    assign pop          = (state == WRITE) && bus.mem_ack;
    assign count_next   = count + CW'(push) - CW'(pop);

    ac_store_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .wdata     ({bus.st_addr, bus.st_data}),
        .head      (head),
        .count     (count)
`ifdef AC_STORE_FWD_EN
        ,
        .entries_o (entries),
        .rd_ptr_o  (rd_ptr)
`endif
    );

    // Sequencer state register; reset drops the write strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state: start on any buffered store, hold WRITE until ack, then
    // insert one turnaround cycle before the next write.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count_next != '0) state_next = WRITE;
            WRITE:   if (bus.mem_ack)      state_next = GAP;
            GAP:     state_next = (count != '0) ? WRITE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.mem_we    = (state == WRITE);
    assign bus.mem_addr  = head[W-1 -: ADDR_W];
    assign bus.mem_wdata = head[DATA_W-1:0];
    assign idle          = (state == IDLE) && (count == '0);
    assign dbg_state     = state;

`ifdef AC_STORE_FWD_EN
    // Walk entries oldest to youngest so the last match is the youngest store.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if ((CW'(i) < count) && (entries[idx][W-1 -: ADDR_W] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[idx][DATA_W-1:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_ac_store_writer.sv
// Testbench for ac_store_writer: directed scenarios plus a randomized phase,
// all checked every cycle against a queue-based model of the store buffer.
`timescale 1ns/1ps
module tb_ac_store_writer;
    import ac_pkg::*;

    localparam int AW    = 8;
    localparam int DW    = 10;
    localparam int DEPTH = 4;

    typedef logic [AW+DW-1:0] ent_t;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   idle;
    state_e dbg_state;

    always #5 clk = ~clk;

    ac_store_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef AC_STORE_FWD_EN
    logic [AW-1:0] fwd_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
`endif

    ac_store_writer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .idle      (idle),
        .dbg_state (dbg_state)
`ifdef AC_STORE_FWD_EN
        ,
        .fwd_addr  (fwd_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data)
`endif
    );

    // ---------------- scoreboard state ----------------
    int            n_tests = 0;
    int            n_fail  = 0;
    ent_t          exp_q[$];       // pending stores, oldest first
    logic [DW-1:0] wr_log[$];      // data of every completed DUT write
    bit            pop_d1 = 0;     // a write completed last cycle
    bit            pop_d2 = 0;     // a write completed two cycles ago
    int            cnt_d1 = 0;     // buffer occupancy last cycle

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drained(input int budget, input string name);
        int k;
        for (k = 0; k < budget; k++) begin
            if (exp_q.size() == 0 && idle) break;
            step();
        end
        chk(name, (exp_q.size() == 0 && idle), 1);
    endtask

    // ---------------- per-cycle compare against the model ----------------
    // Rules: a write is offered whenever stores are pending, except in the
    // cycle right after a completed write (turnaround), and except when that
    // turnaround found the buffer empty (the sequencer then passes through idle).
    always @(negedge clk) begin : compare
        bit            exp_we;
        bit            exp_ready;
        bit            exp_idle;
        bit            do_push;
        bit            do_pop;
        int            sz;
        bit            m_hit;
        logic [DW-1:0] m_data;
        if (!rst_n) begin
            chk("rst_mem_we", bus.mem_we, 0);
            chk("rst_st_ready", bus.st_ready, 1);
            chk("rst_idle", idle, 1);
            exp_q.delete();
            pop_d1 = 0;
            pop_d2 = 0;
            cnt_d1 = 0;
        end else begin
            sz        = exp_q.size();
            exp_we    = (sz != 0) && !pop_d1 && !(pop_d2 && cnt_d1 == 0);
            exp_ready = (sz != DEPTH);
            exp_idle  = (sz == 0) && !pop_d1;
            chk("mem_we", bus.mem_we, exp_we);
            chk("st_ready", bus.st_ready, exp_ready);
            chk("idle", idle, exp_idle);
            if (exp_we) begin
                chk("mem_addr", bus.mem_addr, exp_q[0][AW+DW-1:DW]);
                chk("mem_wdata", bus.mem_wdata, exp_q[0][DW-1:0]);
            end
`ifdef AC_STORE_FWD_EN
            m_hit  = 0;
            m_data = '0;
            foreach (exp_q[i]) begin
                if (exp_q[i][AW+DW-1:DW] == fwd_addr) begin
                    m_hit  = 1;
                    m_data = exp_q[i][DW-1:0];
                end
            end
            chk("fwd_hit", fwd_hit, m_hit);
            if (m_hit) chk("fwd_data", fwd_data, m_data);
`else
            m_hit  = 0;
            m_data = '0;
`endif
            if (bus.mem_we && bus.mem_ack) wr_log.push_back(bus.mem_wdata);
            do_pop  = exp_we && bus.mem_ack;
            do_push = bus.st_valid && exp_ready;
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back({bus.st_addr, bus.st_data});
            pop_d2 = pop_d1;
            pop_d1 = do_pop;
            cnt_d1 = sz;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n0;
        int pv;
        int pa;
        bus.st_valid = 0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.mem_ack  = 0;
`ifdef AC_STORE_FWD_EN
        fwd_addr = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", dbg_state, IDLE);
        rst_n = 1;
        step();

        // T1: single store, immediate ack; strobe appears the cycle after accept.
        bus.st_valid = 1;
        bus.st_addr  = 8'h10;
        bus.st_data  = 10'h2A5;
        bus.mem_ack  = 1;
        chk("t1_idle_before", idle, 1);
        step();
        bus.st_valid = 0;
        chk("t1_we", bus.mem_we, 1);
        chk("t1_addr", bus.mem_addr, 8'h10);
        chk("t1_wdata", bus.mem_wdata, 10'h2A5);
        step();
        chk("t1_gap_we", bus.mem_we, 0);
        chk("t1_gap_idle", idle, 0);
        step();
        chk("t1_idle", idle, 1);
        chk("t1_state", dbg_state, IDLE);

        // T2: five back-to-back stores with no ack; the fifth stalls.
        bus.mem_ack = 0;
        wr_log.delete();
        for (int i = 1; i <= 5; i++) begin
            bus.st_valid = 1;
            bus.st_addr  = 8'h30 + 8'(i);
            bus.st_data  = 10'(i);
            chk("t2_ready", bus.st_ready, (i <= 4));
            step();
        end
        chk("t2_full_ready", bus.st_ready, 0);
        bus.mem_ack = 1;
        step();
        chk("t2_ready_after_pop", bus.st_ready, 1);
        step();
        bus.st_valid = 0;
        wait_drained(60, "t2_drain");
        chk("t2_nwrites", wr_log.size(), 5);
        for (int i = 0; i < 5 && i < wr_log.size(); i++) chk("t2_order", wr_log[i], 32'(i + 1));

        // T3: ack delayed three cycles; the write stays stable for four.
        bus.mem_ack  = 0;
        n0           = wr_log.size();
        bus.st_valid = 1;
        bus.st_addr  = 8'h55;
        bus.st_data  = 10'h155;
        step();
        bus.st_valid = 0;
        for (int j = 0; j < 4; j++) begin
            chk("t3_we", bus.mem_we, 1);
            chk("t3_addr", bus.mem_addr, 8'h55);
            chk("t3_wdata", bus.mem_wdata, 10'h155);
            if (j == 3) bus.mem_ack = 1;
            step();
        end
        bus.mem_ack = 0;
        chk("t3_gap_we", bus.mem_we, 0);
        step();
        chk("t3_single_pop", wr_log.size(), n0 + 1);
        chk("t3_idle", idle, 1);

        // T4: randomized traffic with shifting valid/ack densities.
        pv = 50;
        pa = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                pv = $urandom_range(10, 100);
                pa = $urandom_range(10, 100);
            end
            bus.st_valid = ($urandom_range(0, 99) < pv);
            bus.st_addr  = 8'($urandom_range(0, 7));
            bus.st_data  = 10'($urandom_range(0, 1023));
            bus.mem_ack  = ($urandom_range(0, 99) < pa);
`ifdef AC_STORE_FWD_EN
            fwd_addr = 8'($urandom_range(0, 8));
`endif
            step();
        end
        bus.st_valid = 0;
        bus.mem_ack  = 1;
        wait_drained(60, "t4_drain");

        // T5: reset in the middle of a write with three stores pending.
        bus.mem_ack = 0;
        for (int i = 0; i < 3; i++) begin
            bus.st_valid = 1;
            bus.st_addr  = 8'h70 + 8'(i);
            bus.st_data  = 10'h100 + 10'(i);
            step();
        end
        bus.st_valid = 0;
        chk("t5_we_before", bus.mem_we, 1);
        #3;
        rst_n = 0;
        #1;
        chk("t5_we_async", bus.mem_we, 0);
        chk("t5_idle_async", idle, 1);
        chk("t5_ready_async", bus.st_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        n0 = wr_log.size();
        bus.mem_ack = 1;
        repeat (10) step();
        chk("t5_no_writes", wr_log.size(), n0);
        chk("t5_idle", idle, 1);

`ifdef AC_STORE_FWD_EN
        // T6: two pending stores to one address; the younger one forwards.
        bus.mem_ack  = 0;
        bus.st_valid = 1;
        bus.st_addr  = 8'h20;
        bus.st_data  = 10'h001;
        step();
        bus.st_data  = 10'h3FF;
        step();
        bus.st_valid = 0;
        fwd_addr = 8'h20;
        #1;
        chk("t6_hit", fwd_hit, 1);
        chk("t6_data", fwd_data, 10'h3FF);
        fwd_addr = 8'h21;
        #1;
        chk("t6_miss", fwd_hit, 0);
        bus.mem_ack = 1;
        step();
        wait_drained(30, "t6_drain");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
